// File: rtl/upd7800_bus_responder.sv
// Target side of the uPD7800 external bus: decodes CPU bus cycles, serves read data
// from a local byte memory, commits CPU writes, and keeps open-bus/fetch bookkeeping.
module upd7800_bus_responder #(
  parameter int unsigned MEM_AW   = 13,
  parameter logic [15:0] MEM_BASE = 16'h0000,
  parameter logic [15:0] WP_TOP   = 16'h1000
) (
  input  logic              CLK,
  input  logic              RESETB,
  input  logic              CP1_POSEDGE,
  input  logic              CP2_NEGEDGE,
  input  logic [15:0]       A,
  input  logic [7:0]        DB_O,
  input  logic              DB_OE,
  input  logic              M1,
  output logic [7:0]        DB_I,
  input  logic              LOAD_EN,
  input  logic [MEM_AW-1:0] LOAD_ADDR,
  input  logic [7:0]        LOAD_DATA,
  output logic [15:0]       FETCH_CNT,
  output logic [7:0]        LAST_OP,
  output logic              COLL
);

  localparam int unsigned MEM_DEPTH = 1 << MEM_AW;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       cyc_a_q, cyc_a_d;
  logic              cyc_wr_q, cyc_wr_d;
  logic              cyc_m1_q, cyc_m1_d;
  logic              hit_q, hit_d;
  logic              dv_q, dv_d;
  logic [7:0]        db_i_q, db_i_d;
  logic [7:0]        ob_q, ob_d;
  logic [15:0]       fetch_cnt_q, fetch_cnt_d;
  logic [7:0]        last_op_q, last_op_d;
  logic              coll_q, coll_d;

  logic [7:0]        mem [MEM_DEPTH];
  logic [7:0]        rd_data_q;

  logic              commit_s;
  logic              cpu_wr_s;
  logic              mem_we_s;
  logic [MEM_AW-1:0] mem_wa_s;
  logic [7:0]        mem_wd_s;

  // A commit is only honoured once DB_I has been loaded from this cycle's read data.
  always_comb begin
    commit_s = (state_q == S_DATA) && CP2_NEGEDGE && dv_q;
    cpu_wr_s = commit_s && cyc_wr_q && hit_q && (cyc_a_q >= WP_TOP);
    mem_we_s = LOAD_EN || cpu_wr_s;
    if (LOAD_EN) begin
      mem_wa_s = LOAD_ADDR;
      mem_wd_s = LOAD_DATA;
    end else begin
      mem_wa_s = cyc_a_q[MEM_AW-1:0];
      mem_wd_s = DB_O;
    end
  end

  // Byte array with registered read; the read register samples before the write lands.
  always_ff @(posedge CLK) begin
    if (state_q == S_ADDR) begin
      rd_data_q <= mem[A[MEM_AW-1:0]];
    end
    if (mem_we_s) begin
      mem[mem_wa_s] <= mem_wd_s;
    end
  end

  // State and bookkeeping registers.
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      state_q     <= S_IDLE;
      cyc_a_q     <= 16'h0000;
      cyc_wr_q    <= 1'b0;
      cyc_m1_q    <= 1'b0;
      hit_q       <= 1'b0;
      dv_q        <= 1'b0;
      db_i_q      <= 8'hFF;
      ob_q        <= 8'hFF;
      fetch_cnt_q <= 16'h0000;
      last_op_q   <= 8'h00;
      coll_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_a_q     <= cyc_a_d;
      cyc_wr_q    <= cyc_wr_d;
      cyc_m1_q    <= cyc_m1_d;
      hit_q       <= hit_d;
      dv_q        <= dv_d;
      db_i_q      <= db_i_d;
      ob_q        <= ob_d;
      fetch_cnt_q <= fetch_cnt_d;
      last_op_q   <= last_op_d;
      coll_q      <= coll_d;
    end
  end

  // Next-state decode; a CP1 in DATA either chains a new cycle or aborts the current one.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (CP1_POSEDGE) begin
          state_d = S_ADDR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADDR: begin
        state_d = S_DATA;
      end
      S_DATA: begin
        if (CP2_NEGEDGE) begin
          if (CP1_POSEDGE) begin
            state_d = S_ADDR;
          end else begin
            state_d = S_IDLE;
          end
        end else if (CP1_POSEDGE) begin
          state_d = S_ADDR;
        end else begin
          state_d = S_DATA;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Cycle capture, bus data selection, commit bookkeeping and collision detection.
  always_comb begin
    cyc_a_d     = cyc_a_q;
    cyc_wr_d    = cyc_wr_q;
    cyc_m1_d    = cyc_m1_q;
    hit_d       = hit_q;
    dv_d        = dv_q;
    db_i_d      = db_i_q;
    ob_d        = ob_q;
    fetch_cnt_d = fetch_cnt_q;
    last_op_d   = last_op_q;
    coll_d      = coll_q;
    case (state_q)
      S_IDLE: begin
        dv_d = 1'b0;
      end
      S_ADDR: begin
        cyc_a_d  = A;
        cyc_wr_d = DB_OE;
        cyc_m1_d = M1;
        hit_d    = (A[15:MEM_AW] == MEM_BASE[15:MEM_AW]);
        dv_d     = 1'b0;
        if (CP2_NEGEDGE) begin
          coll_d = 1'b1;
        end else begin
          coll_d = coll_q;
        end
      end
      S_DATA: begin
        if (cyc_wr_q) begin
          db_i_d = DB_O;
        end else if (hit_q) begin
          db_i_d = rd_data_q;
        end else begin
          db_i_d = ob_q;
        end
        dv_d = 1'b1;
        if (CP2_NEGEDGE) begin
          dv_d = 1'b0;
          if (dv_q) begin
            ob_d = db_i_q;
            if (cyc_m1_q && !cyc_wr_q) begin
              fetch_cnt_d = fetch_cnt_q + 16'd1;
              last_op_d   = db_i_q;
            end else begin
              fetch_cnt_d = fetch_cnt_q;
            end
            if (cpu_wr_s && LOAD_EN) begin
              coll_d = 1'b1;
            end else begin
              coll_d = coll_q;
            end
          end else begin
            // Strobe arrived before DB_I was valid: treat as a spacing violation.
            coll_d = 1'b1;
          end
        end else if (CP1_POSEDGE) begin
          coll_d = 1'b1;
          dv_d   = 1'b0;
        end else begin
          coll_d = coll_q;
        end
      end
      default: begin
        dv_d = 1'b0;
      end
    endcase
  end

  assign DB_I      = db_i_q;
  assign FETCH_CNT = fetch_cnt_q;
  assign LAST_OP   = last_op_q;
  assign COLL      = coll_q;

endmodule

// File: tb/tb_upd7800_bus_responder.sv
// Directed bench for upd7800_bus_responder: preload, fetch, protect, open bus,
// load collision, mid-cycle reset and aborted-cycle scenarios.
module tb_upd7800_bus_responder;

  logic        CLK = 1'b0;
  logic        RESETB;
  logic        CP1_POSEDGE;
  logic        CP2_NEGEDGE;
  logic [15:0] A;
  logic [7:0]  DB_O;
  logic        DB_OE;
  logic        M1;
  logic [7:0]  DB_I;
  logic        LOAD_EN;
  logic [12:0] LOAD_ADDR;
  logic [7:0]  LOAD_DATA;
  logic [15:0] FETCH_CNT;
  logic [7:0]  LAST_OP;
  logic        COLL;

  int checks   = 0;
  int failures = 0;
  logic [7:0] bus;

  upd7800_bus_responder #(
    .MEM_AW(13),
    .MEM_BASE(16'h0000),
    .WP_TOP(16'h1000)
  ) dut (
    .CLK(CLK), .RESETB(RESETB), .CP1_POSEDGE(CP1_POSEDGE), .CP2_NEGEDGE(CP2_NEGEDGE),
    .A(A), .DB_O(DB_O), .DB_OE(DB_OE), .M1(M1), .DB_I(DB_I),
    .LOAD_EN(LOAD_EN), .LOAD_ADDR(LOAD_ADDR), .LOAD_DATA(LOAD_DATA),
    .FETCH_CNT(FETCH_CNT), .LAST_OP(LAST_OP), .COLL(COLL)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_byte(input logic [12:0] addr, input logic [7:0] data);
    @(negedge CLK);
    LOAD_EN   = 1'b1;
    LOAD_ADDR = addr;
    LOAD_DATA = data;
    @(negedge CLK);
    LOAD_EN   = 1'b0;
  endtask

  // One full bus cycle; DB_I is sampled while CP2 is pending, before the commit edge.
  task automatic do_cycle(input logic [15:0] addr, input logic wr, input logic [7:0] d,
                          input logic m1, input logic ld, input logic [7:0] ld_d,
                          output logic [7:0] seen);
    @(negedge CLK);
    CP1_POSEDGE = 1'b1;
    @(negedge CLK);
    CP1_POSEDGE = 1'b0;
    A     = addr;
    DB_OE = wr;
    DB_O  = d;
    M1    = m1;
    @(negedge CLK);
    @(negedge CLK);
    CP2_NEGEDGE = 1'b1;
    if (ld) begin
      LOAD_EN   = 1'b1;
      LOAD_ADDR = addr[12:0];
      LOAD_DATA = ld_d;
    end
    #1 seen = DB_I;
    @(negedge CLK);
    CP2_NEGEDGE = 1'b0;
    LOAD_EN     = 1'b0;
    DB_OE       = 1'b0;
    M1          = 1'b0;
  endtask

  initial begin
    RESETB = 1'b0; CP1_POSEDGE = 1'b0; CP2_NEGEDGE = 1'b0;
    A = 16'h0000; DB_O = 8'h00; DB_OE = 1'b0; M1 = 1'b0;
    LOAD_EN = 1'b0; LOAD_ADDR = 13'h0000; LOAD_DATA = 8'h00;

    // Preload while the CPU side is held in reset.
    load_byte(13'h0000, 8'h4E);
    load_byte(13'h0001, 8'h12);
    load_byte(13'h0800, 8'h33);
    load_byte(13'h1801, 8'h3C);
    chk("rst_db_i", {8'h00, DB_I}, 16'h00FF);
    chk("rst_fetch", FETCH_CNT, 16'h0000);
    chk("rst_last_op", {8'h00, LAST_OP}, 16'h0000);
    chk("rst_coll", {15'h0000, COLL}, 16'h0000);
    @(negedge CLK);
    RESETB = 1'b1;
    @(negedge CLK);

    do_cycle(16'h0000, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, bus);
    chk("fetch0", {8'h00, bus}, 16'h004E);
    do_cycle(16'h0001, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, bus);
    chk("fetch1", {8'h00, bus}, 16'h0012);
    chk("fetch_cnt2", FETCH_CNT, 16'h0002);
    chk("last_op12", {8'h00, LAST_OP}, 16'h0012);

    do_cycle(16'h1800, 1'b1, 8'h5A, 1'b0, 1'b0, 8'h00, bus);
    chk("wr_echo5a", {8'h00, bus}, 16'h005A);
    do_cycle(16'h1800, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, bus);
    chk("rd_1800", {8'h00, bus}, 16'h005A);
    do_cycle(16'h0800, 1'b1, 8'h77, 1'b0, 1'b0, 8'h00, bus);
    chk("wr_echo77", {8'h00, bus}, 16'h0077);
    do_cycle(16'h0800, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, bus);
    chk("rd_protected", {8'h00, bus}, 16'h0033);
    chk("fetch_cnt_nm1", FETCH_CNT, 16'h0002);

    do_cycle(16'h1800, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, bus);
    chk("rd_1800_again", {8'h00, bus}, 16'h005A);
    do_cycle(16'hC000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, bus);
    chk("open_bus1", {8'h00, bus}, 16'h005A);
    do_cycle(16'hC001, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, bus);
    chk("open_bus2", {8'h00, bus}, 16'h005A);
    chk("coll_clean", {15'h0000, COLL}, 16'h0000);

    // Host load lands in the same clock as the CPU write commit.
    do_cycle(16'h1800, 1'b1, 8'h22, 1'b0, 1'b1, 8'h11, bus);
    chk("coll_load", {15'h0000, COLL}, 16'h0001);
    do_cycle(16'h1800, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, bus);
    chk("load_wins", {8'h00, bus}, 16'h0011);

    // Reset asserted while the responder sits in DATA.
    @(negedge CLK);
    CP1_POSEDGE = 1'b1;
    @(negedge CLK);
    CP1_POSEDGE = 1'b0;
    A = 16'h0001; M1 = 1'b1;
    @(negedge CLK);
    RESETB = 1'b0;
    #1;
    chk("mid_rst_db_i", {8'h00, DB_I}, 16'h00FF);
    chk("mid_rst_fetch", FETCH_CNT, 16'h0000);
    chk("mid_rst_coll", {15'h0000, COLL}, 16'h0000);
    @(negedge CLK);
    RESETB = 1'b1; M1 = 1'b0;
    @(negedge CLK);
    do_cycle(16'h0000, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, bus);
    chk("mem_retained", {8'h00, bus}, 16'h004E);
    chk("fetch_after_rst", FETCH_CNT, 16'h0001);

    // Start a write to 0x1801, then restart with CP1 before any CP2.
    @(negedge CLK);
    CP1_POSEDGE = 1'b1;
    @(negedge CLK);
    CP1_POSEDGE = 1'b0;
    A = 16'h1801; DB_OE = 1'b1; DB_O = 8'h99;
    do_cycle(16'h1801, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, bus);
    chk("abort_coll", {15'h0000, COLL}, 16'h0001);
    chk("abort_no_write", {8'h00, bus}, 16'h003C);
    chk("abort_fetch", FETCH_CNT, 16'h0002);
    chk("abort_last_op", {8'h00, LAST_OP}, 16'h003C);
    do_cycle(16'h0001, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, bus);
    chk("post_abort_rd", {8'h00, bus}, 16'h0012);
    chk("post_abort_cnt", FETCH_CNT, 16'h0003);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/upd7800_bus_responder.md
Name: upd7800_bus_responder

Overview:
- Target side of the uPD7800 CPU external bus: decodes each CPU bus cycle, returns read data on DB_I and commits CPU writes into a local byte memory.
- Sits beside the CPU core on the same CLK and phase enables, and replaces discrete ROM/RAM glue.
- Provides a host load port for preloading program images, a write-protected ROM window, open-bus emulation for unmapped reads, and fetch statistics.

Parameters:
- MEM_AW, 13, local memory address width; the array holds 2^MEM_AW bytes.
- MEM_BASE, 16'h0000, CPU address of memory byte 0. Must be aligned to 2^MEM_AW.
- WP_TOP, 16'h1000, CPU addresses in [MEM_BASE, WP_TOP) are read-only to the CPU.

Ports:
- CLK  in  1  system clock
- RESETB  in  1  asynchronous active-low reset
- CP1_POSEDGE  in  1  phase-1 rising enable; marks the start of a bus cycle
- CP2_NEGEDGE  in  1  phase-2 falling enable; the CPU samples DB_I here and the responder commits writes here
- A  in  16  CPU address output
- DB_O  in  8  CPU write data
- DB_OE  in  1  CPU drives the bus (write cycle)
- M1  in  1  opcode-fetch cycle
- DB_I  out  8  read data to the CPU
- LOAD_EN  in  1  host write strobe
- LOAD_ADDR  in  MEM_AW  host write address
- LOAD_DATA  in  8  host write data
- FETCH_CNT  out  16  count of completed M1 read cycles
- LAST_OP  out  8  data returned on the most recent completed M1 cycle
- COLL  out  1  sticky flag: load/CPU write collision or aborted cycle

Behaviour:
- Reset (async, RESETB=0): state=IDLE, DB_I=8'hFF, open-bus latch=8'hFF, FETCH_CNT=0, LAST_OP=0, COLL=0. Memory contents are not cleared.
- FSM states: IDLE, ADDR, DATA.
- IDLE: on CP1_POSEDGE go to ADDR. The CPU's address register updates on that same edge, so A is not yet valid.
- ADDR (exactly 1 CLK):
  - Capture A, DB_OE and M1 into cyc_a, cyc_wr and cyc_m1.
  - Compute hit = (A[15:MEM_AW] == MEM_BASE[15:MEM_AW]).
  - Issue the synchronous memory read at A[MEM_AW-1:0].
  - Go to DATA.
- DATA, read data selection (memory read data is available 1 CLK after ADDR):
  - On a read cycle with hit: DB_I = memory data.
  - On a read cycle without hit: DB_I = open-bus latch.
  - On a write cycle: DB_I = DB_O, continuously, so write data echoes on the bus.
  - DB_I must be stable from 2 CLK after CP1_POSEDGE until CP2_NEGEDGE.
- DATA, on CP2_NEGEDGE:
  - Write with hit and cyc_a >= WP_TOP: mem[cyc_a] <= DB_O.
  - Write that misses or falls in the protected window: dropped silently.
  - Open-bus latch <= DB_I value (reads and writes alike).
  - If cyc_m1 and it is a read: FETCH_CNT <= FETCH_CNT+1 (wraps FFFF->0000) and LAST_OP <= DB_I.
  - Go to IDLE. If CP1_POSEDGE is asserted in the same CLK, go directly to ADDR.
- DATA, on CP1_POSEDGE without CP2_NEGEDGE (cycle aborted):
  - COLL <= 1.
  - No write, no count update.
  - Restart in ADDR.
- CP2_NEGEDGE seen in IDLE or ADDR: ignored (no commit). In ADDR this also sets COLL.
- Minimum spacing: CP1_POSEDGE to CP2_NEGEDGE >= 3 CLK. Shorter spacing is treated as the abort/ignored case above.
- Load port:
  - LOAD_EN writes mem[LOAD_ADDR] <= LOAD_DATA in the same CLK.
  - Allowed at any time, including while the CPU is held in reset. The protection window does not apply.
  - If LOAD_EN coincides with a CPU write commit, the load wins, the CPU write is dropped and COLL <= 1.
  - A CPU read of an address being loaded in the same CLK as ADDR returns the old value (read-before-write).
- COLL clears only on reset.
- DB_I holds its last value in IDLE.

Test Plan:
- Preload via LOAD_EN: 0x0000=0x4E, 0x0001=0x12. Run two M1 reads at A=0x0000 and 0x0001 -> DB_I=0x4E then 0x12 at each CP2_NEGEDGE, FETCH_CNT=2, LAST_OP=0x12.
- Write DB_O=0x5A to A=0x1800, then read it back -> read returns 0x5A. Write 0x77 to A=0x0800 (protected) -> a following read returns the preloaded value unchanged.
- Read unmapped A=0xC000 right after a cycle whose bus value was 0x5A -> DB_I=0x5A (open bus). Next unmapped read -> still 0x5A.
- Issue CP1_POSEDGE twice with no CP2_NEGEDGE between -> COLL=1, no write occurs, FETCH_CNT unchanged, next full cycle completes normally.
- LOAD_EN to offset 0x1800 with data 0x11 in the same CLK as a CPU write commit of 0x22 to 0x1800 -> mem=0x11, COLL=1.
- Pull RESETB low mid-DATA -> immediately DB_I=0xFF, FETCH_CNT=0, state IDLE. Memory retains preloaded bytes: after reset release, read 0x0000 -> 0x4E.
